jtcontra_sndcmd: RTL and testbench

Parametrised command mailbox between the main CPU and the sound CPU, replacing the single sound latch plus edge-triggered IRQ flip-flop used by the current sound subsystems. Main-CPU writes are queued in a FIFO of `DEPTH` entries. The sound CPU gets an interrupt in a selectable mode and reads entries in order. A one-entry reply latch carries status from the sound CPU back to the main CPU. The block sits next to the sound CPU, between the main-CPU write decode and the sound-CPU `cpu_din` multiplexer.

---
 rtl/jtcontra_snd_defs.sv | 7 +
 rtl/jtcontra_sndcmd_fifo.sv | 60 ++++++
 rtl/jtcontra_sndcmd.sv | 89 ++++++++
 tb/tb_jtcontra_sndcmd.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/jtcontra_snd_defs.sv
// Shared constants for the main-to-sound command mailbox.
package jtcontra_snd_defs;

  localparam int SNDCMD_IRQ_PULSE = 0;
  localparam int SNDCMD_IRQ_LEVEL = 1;

endpackage

// File: rtl/jtcontra_sndcmd_fifo.sv
// Command FIFO with registered head output that holds the last popped value once drained.
module jtcontra_sndcmd_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic          do_push, do_pop;

  assign full    = cnt == FULL_CNT;
  assign empty   = cnt == '0;
  assign rd_nxt  = rd_ptr + 1'b1;
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot a push into a full FIFO needs
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // the entry being written is not yet in mem, so bypass it when it becomes head
      if (do_pop) begin
        if (cnt > ONE_CNT)   dout <= mem[rd_nxt];
        else if (do_push)    dout <= din;
      end else if (do_push && empty) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/jtcontra_sndcmd.sv
// Main-to-sound command mailbox: edge-detected selects, command FIFO, IRQ, overflow flag, reply latch.
module jtcontra_sndcmd
  import jtcontra_snd_defs::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 2,
  parameter int IRQ_MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          main_wr,
  input  logic [DW-1:0] main_din,
  input  logic          main_rd,
  output logic [DW-1:0] main_reply,
  output logic          main_reply_ok,
  output logic          main_full,
  output logic          ovf,
  input  logic          ovf_clr,
  input  logic          snd_rd,
  output logic [DW-1:0] snd_dout,
  output logic          snd_empty,
  output logic [AW:0]   snd_cnt,
  input  logic          snd_wr,
  input  logic [DW-1:0] snd_din,
  input  logic          irq_ack,
  output logic          snd_irq_n
);

  logic main_wr_q, main_rd_q, snd_rd_q, snd_wr_q, irq_ack_q;
  logic push, pop, rep_wr, rep_rd, ack;
  logic pop_ok, push_ok, push_drop;
  logic irq_pend;

  assign push   = main_wr & ~main_wr_q;
  assign pop    = ~snd_rd & snd_rd_q;
  assign rep_wr = snd_wr & ~snd_wr_q;
  assign rep_rd = ~main_rd & main_rd_q;
  assign ack    = irq_ack & ~irq_ack_q;

  assign pop_ok    = pop & ~snd_empty;
  assign push_ok   = push & (~main_full | pop_ok);
  assign push_drop = push & ~push_ok;

  jtcontra_sndcmd_fifo #(.DW(DW), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (main_din),
    .dout  (snd_dout),
    .cnt   (snd_cnt),
    .full  (main_full),
    .empty (snd_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_wr_q     <= 1'b0;
      main_rd_q     <= 1'b0;
      snd_rd_q      <= 1'b0;
      snd_wr_q      <= 1'b0;
      irq_ack_q     <= 1'b0;
      irq_pend      <= 1'b0;
      ovf           <= 1'b0;
      main_reply    <= '0;
      main_reply_ok <= 1'b0;
    end else begin
      main_wr_q <= main_wr;
      main_rd_q <= main_rd;
      snd_rd_q  <= snd_rd;
      snd_wr_q  <= snd_wr;
      irq_ack_q <= irq_ack;
      if (push_ok)  irq_pend <= 1'b1;
      else if (ack) irq_pend <= 1'b0;
      if (push_drop)    ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      // a fresh reply wins over a read finishing in the same cycle
      if (rep_wr) begin
        main_reply    <= snd_din;
        main_reply_ok <= 1'b1;
      end else if (rep_rd) begin
        main_reply_ok <= 1'b0;
      end
    end
  end

  assign snd_irq_n = (IRQ_MODE == SNDCMD_IRQ_LEVEL) ? snd_empty : ~irq_pend;

endmodule

// File: tb/tb_jtcontra_sndcmd.sv
// Randomized + directed bench: pulse-mode and level-mode instances checked against a queue model.
module tb_jtcontra_sndcmd;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       main_wr = 0, main_rd = 0, ovf_clr = 0, snd_rd = 0, snd_wr = 0, irq_ack = 0;
  logic [7:0] main_din = 0, snd_din = 0;

  logic [7:0] a_reply, a_dout, b_reply, b_dout;
  logic       a_rok, a_full, a_ovf, a_empty, a_irq_n;
  logic       b_rok, b_full, b_ovf, b_empty, b_irq_n;
  logic [2:0] a_cnt, b_cnt;

  int errors = 0;
  int checks = 0;

  // model state
  logic [7:0] q[$];
  logic [7:0] m_last, m_reply;
  logic       m_pend, m_ovf, m_rok;
  logic       pv_wr, pv_rd, pv_srd, pv_swr, pv_ack;

  always #5 clk = ~clk;

  jtcontra_sndcmd #(.DW(8), .AW(2), .IRQ_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .main_wr(main_wr), .main_din(main_din), .main_rd(main_rd),
    .main_reply(a_reply), .main_reply_ok(a_rok), .main_full(a_full), .ovf(a_ovf),
    .ovf_clr(ovf_clr), .snd_rd(snd_rd), .snd_dout(a_dout), .snd_empty(a_empty),
    .snd_cnt(a_cnt), .snd_wr(snd_wr), .snd_din(snd_din), .irq_ack(irq_ack),
    .snd_irq_n(a_irq_n)
  );

  jtcontra_sndcmd #(.DW(8), .AW(2), .IRQ_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .main_wr(main_wr), .main_din(main_din), .main_rd(main_rd),
    .main_reply(b_reply), .main_reply_ok(b_rok), .main_full(b_full), .ovf(b_ovf),
    .ovf_clr(ovf_clr), .snd_rd(snd_rd), .snd_dout(b_dout), .snd_empty(b_empty),
    .snd_cnt(b_cnt), .snd_wr(snd_wr), .snd_din(snd_din), .irq_ack(irq_ack),
    .snd_irq_n(b_irq_n)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last = 0; m_reply = 0; m_pend = 0; m_ovf = 0; m_rok = 0;
    pv_wr = 0; pv_rd = 0; pv_srd = 0; pv_swr = 0; pv_ack = 0;
  endtask

  task automatic model_step();
    bit pu, po, sw, mr, ak, acc, drop;
    pu = main_wr && !pv_wr;
    po = !snd_rd && pv_srd;
    sw = snd_wr && !pv_swr;
    mr = !main_rd && pv_rd;
    ak = irq_ack && !pv_ack;
    acc = 0; drop = 0;
    if (po && q.size() > 0) m_last = q.pop_front();
    if (pu) begin
      if (q.size() < DEPTH) begin q.push_back(main_din); acc = 1; end
      else drop = 1;
    end
    if (acc) m_pend = 1; else if (ak) m_pend = 0;
    if (drop) m_ovf = 1; else if (ovf_clr) m_ovf = 0;
    if (sw) begin m_reply = snd_din; m_rok = 1; end
    else if (mr) m_rok = 0;
    pv_wr = main_wr; pv_rd = main_rd; pv_srd = snd_rd; pv_swr = snd_wr; pv_ack = irq_ack;
  endtask

  task automatic compare_all();
    logic [7:0] hd;
    hd = (q.size() > 0) ? q[0] : m_last;
    chk("dout_a", a_dout, hd);
    chk("dout_b", b_dout, hd);
    chk("cnt", a_cnt, q.size());
    chk("empty", a_empty, q.size() == 0);
    chk("full", a_full, q.size() == DEPTH);
    chk("ovf", a_ovf, m_ovf);
    chk("reply", a_reply, m_reply);
    chk("reply_ok", a_rok, m_rok);
    chk("irq_pulse", a_irq_n, !m_pend);
    chk("irq_level", b_irq_n, q.size() == 0);
    chk("cnt_b", b_cnt, q.size());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic push(input logic [7:0] b);
    main_din = b; main_wr = 1; tick(); main_wr = 0; tick();
  endtask

  task automatic pop();
    snd_rd = 1; tick(); snd_rd = 0; tick();
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_irq", a_irq_n, 1); chk("rst_empty", a_empty, 1); chk("rst_dout", a_dout, 0);

    // 1: ordering and last-value hold
    push(8'h12); push(8'h34);
    chk("t1_cnt", a_cnt, 2); chk("t1_head", a_dout, 8'h12);
    pop(); chk("t1_head2", a_dout, 8'h34);
    pop(); chk("t1_empty", a_empty, 1); chk("t1_hold", a_dout, 8'h34);

    // 2: overflow
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    chk("t2_full", a_full, 1); chk("t2_ovf", a_ovf, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_pop", a_dout, 8'hA0 + i);
      pop();
    end
    ovf_clr = 1; tick(); ovf_clr = 0; tick();
    chk("t2_clr", a_ovf, 0);

    // 3: pulse-mode IRQ
    push(8'h55); chk("t3_irq", a_irq_n, 0);
    irq_ack = 1; tick(); irq_ack = 0; tick(); chk("t3_ack", a_irq_n, 1);
    main_din = 8'h56; main_wr = 1; irq_ack = 1; tick();
    main_wr = 0; irq_ack = 0; tick(); chk("t3_both", a_irq_n, 0);
    pop(); pop();

    // 4: level-mode IRQ ignores ack
    push(8'h01); push(8'h02);
    irq_ack = 1; tick(); irq_ack = 0; tick(); chk("t4_ack", b_irq_n, 0);
    pop(); chk("t4_pop1", b_irq_n, 0);
    pop(); chk("t4_pop2", b_irq_n, 1);

    // 5: push and pop together while full
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    snd_rd = 1; tick();
    main_din = 8'hCF; main_wr = 1; snd_rd = 0; tick(); main_wr = 0; tick();
    chk("t5_cnt", a_cnt, 4); chk("t5_ovf", a_ovf, 0);
    for (int i = 0; i < 3; i++) pop();
    chk("t5_last", a_dout, 8'hCF);
    pop();

    // 6: reply latch, then async reset mid-queue
    snd_din = 8'h7E; snd_wr = 1; tick(); snd_wr = 0; tick();
    chk("t6_ok", a_rok, 1); chk("t6_reply", a_reply, 8'h7E);
    main_rd = 1; tick(); main_rd = 0; tick(); chk("t6_rd", a_rok, 0);
    snd_din = 8'h3C; snd_wr = 1; tick(); snd_wr = 0; tick();
    push(8'h99); push(8'h98);
    #2 rst_n = 1'b0;
    #1;
    chk("r_irq", a_irq_n, 1); chk("r_empty", a_empty, 1); chk("r_full", a_full, 0);
    chk("r_cnt", a_cnt, 0); chk("r_dout", a_dout, 0); chk("r_reply", a_reply, 0);
    chk("r_ok", a_rok, 0); chk("r_ovf", a_ovf, 0); chk("r_irq_b", b_irq_n, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      main_wr  = ($urandom_range(0, 99) < 50);
      snd_rd   = ($urandom_range(0, 99) < (n % 400 < 200 ? 25 : 60));
      main_rd  = ($urandom_range(0, 99) < 40);
      snd_wr   = ($urandom_range(0, 99) < 30);
      irq_ack  = ($urandom_range(0, 99) < 30);
      ovf_clr  = ($urandom_range(0, 7) == 0);
      main_din = 8'($urandom);
      snd_din  = 8'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
